sobel_output_writer: RTL
========================

SOBEL_OUTPUT_WRITER -- requirements
Module: sobel_output_writer

Interface
REQ-001 SHALL have parameter IMG_W, default 5, input image width in pixels.
REQ-002 SHALL have parameter IMG_H, default 5, input image height in pixels.
REQ-003 SHALL have parameter ADDR_W, default 8, output memory address width.
REQ-004 SHALL have parameter DATA_W, default 8, gradient pixel width.
REQ-005 SHALL have parameter FIFO_DEPTH, default 4 (power of 2 >= 2), internal result buffer depth.
REQ-006 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-007 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-008 SHALL have port start  input  1  single-cycle frame start request.
REQ-009 SHALL have port in_valid  input  1  Sobel result pixel valid.
REQ-010 SHALL have port in_data  input  DATA_W  Sobel result pixel, raster order.
REQ-011 SHALL have port in_ready  output  1  writer accepts in_data this cycle.
REQ-012 SHALL have port wr_en  output  1  output-memory write request (registered).
REQ-013 SHALL have port wr_addr  output  ADDR_W  output-memory write address (registered).
REQ-014 SHALL have port wr_data  output  DATA_W  output-memory write data (registered).
REQ-015 SHALL have port wr_ready  input  1  memory accepts the write this cycle.
REQ-016 SHALL have port busy  output  1  frame in progress.
REQ-017 SHALL have port done  output  1  frame fully written, held until next start.

Function
REQ-018 SHALL define OUT_W=IMG_W-2, OUT_H=IMG_H-2, NPIX=OUT_W*OUT_H (valid-region output image).
REQ-019 SHALL implement FSM states IDLE, RUN, DONE; reset state IDLE.
REQ-020 SHALL transition IDLE->RUN or DONE->RUN on start=1, clearing accept count, write row/col, FIFO and done.
REQ-021 SHALL ignore start while in RUN.
REQ-022 SHALL drive in_ready=1 only in RUN when FIFO not full and accepted count < NPIX; in_ready SHALL NOT depend on wr_ready or in_valid combinationally.
REQ-023 SHALL push in_data into FIFO on the edge where in_valid && in_ready.
REQ-024 SHALL treat wr_en/wr_addr/wr_data as an output register: loaded from FIFO head when (wr_en=0 or wr_ready=1) and FIFO non-empty; FIFO popped on that same edge.
REQ-025 SHALL hold wr_en, wr_addr, wr_data stable while wr_en=1 and wr_ready=0.
REQ-026 SHALL clear wr_en on the write-handshake edge when FIFO is empty.
REQ-027 SHALL compute wr_addr = out_row*OUT_W + out_col, truncated to ADDR_W; col advances per loaded write, wraps to 0 at OUT_W-1 with row+1.
REQ-028 SHALL give minimum latency of 2 edges from input acceptance to wr_en=1 with that pixel.
REQ-029 SHALL support simultaneous FIFO push and pop in one cycle with occupancy unchanged.
REQ-030 SHALL transition RUN->DONE on the wr_en && wr_ready edge of write index NPIX-1; done=1 and busy=0 from that edge.
REQ-031 SHALL assert busy=1 exactly in RUN.
REQ-032 SHALL sustain one write per cycle when in_valid=1 and wr_ready=1 continuously.

Reset
REQ-033 SHALL on rst_n=0 immediately force state IDLE, FIFO empty, counters 0, in_ready=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0.
REQ-034 SHALL on reset mid-frame discard buffered and in-flight pixels; writing resumes only after a new start.

Verification
REQ-035 SHALL cover: defaults, start, in_valid=1 and wr_ready=1 continuously, data 1..9 -> wr_addr 0..8 with wr_data 1..9, one per cycle, done=1 after 9th handshake.
REQ-036 SHALL cover: wr_ready=0 for 10 cycles mid-frame -> wr_en/addr/data held, FIFO fills to 4, in_ready=0, no pixel lost or duplicated.
REQ-037 SHALL cover: in_valid every third cycle -> wr_en gaps, addresses still contiguous 0..8.
REQ-038 SHALL cover: 10th in_valid after 9 accepted -> in_ready=0, pixel not accepted.
REQ-039 SHALL cover: rst_n low after 4 writes -> all outputs 0 same cycle; new start rewrites from wr_addr 0.
REQ-040 SHALL cover: start pulse during RUN -> ignored; start in DONE -> done=0, busy=1, second frame addresses 0..8.

Source files
------------

// File: rtl/sobel_output_writer.sv
// Sobel result writer: buffers valid-region gradient pixels in a small FIFO and
// streams them into output memory through a registered write port.
module sobel_output_writer #(
    parameter int IMG_W      = 5,
    parameter int IMG_H      = 5,
    parameter int ADDR_W     = 8,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    input  logic              wr_ready,
    output logic              busy,
    output logic              done
);

    localparam int OUT_W = IMG_W - 2;
    localparam int OUT_H = IMG_H - 2;
    localparam int NPIX  = OUT_W * OUT_H;

    localparam int CNT_W = (NPIX > 1) ? $clog2(NPIX + 1) : 1;
    localparam int COL_W = (OUT_W > 1) ? $clog2(OUT_W) : 1;
    localparam int ROW_W = $clog2(OUT_H + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int OCC_W = $clog2(FIFO_DEPTH + 1);

    localparam logic [CNT_W-1:0] NPIX_C  = CNT_W'(NPIX);
    localparam logic [COL_W-1:0] COL_MAX = COL_W'(OUT_W - 1);
    localparam logic [OCC_W-1:0] OCC_MAX = OCC_W'(FIFO_DEPTH);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]        state_q;
    logic [CNT_W-1:0]  acc_q;
    logic [CNT_W-1:0]  ld_q;
    logic [ROW_W-1:0]  row_q;
    logic [COL_W-1:0]  col_q;
    logic [PTR_W-1:0]  wptr_q;
    logic [PTR_W-1:0]  rptr_q;
    logic [OCC_W-1:0]  occ_q;
    logic [DATA_W-1:0] mem [FIFO_DEPTH];

    logic              push;
    logic              pop;
    logic              last_hs;
    logic              frame_start;
    logic [ADDR_W-1:0] lin_addr;

    // in_ready is derived from registered state only, never from wr_ready/in_valid
    assign in_ready    = (state_q == RUN) && (occ_q != OCC_MAX) && (acc_q < NPIX_C);
    assign push        = in_valid && in_ready;
    assign pop         = (state_q == RUN) && (occ_q != '0) && (!wr_en || wr_ready);
    // every pixel has been loaded, so the one on the port now is the final write
    assign last_hs     = (state_q == RUN) && wr_en && wr_ready && (ld_q == NPIX_C);
    assign frame_start = start && (state_q != RUN);
    assign lin_addr    = ADDR_W'(row_q) * ADDR_W'(OUT_W) + ADDR_W'(col_q);

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr_q] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            ld_q    <= '0;
            row_q   <= '0;
            col_q   <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            occ_q   <= '0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else if (frame_start) begin
            state_q <= RUN;
            acc_q   <= '0;
            ld_q    <= '0;
            row_q   <= '0;
            col_q   <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            occ_q   <= '0;
            wr_en   <= 1'b0;
        end else if (state_q == RUN) begin
            if (push) begin
                wptr_q <= wptr_q + 1'b1;
                acc_q  <= acc_q + 1'b1;
            end

            if (pop) begin
                wr_en   <= 1'b1;
                wr_addr <= lin_addr;
                wr_data <= mem[rptr_q];
                rptr_q  <= rptr_q + 1'b1;
                ld_q    <= ld_q + 1'b1;
                if (col_q == COL_MAX) begin
                    col_q <= '0;
                    row_q <= row_q + 1'b1;
                end else begin
                    col_q <= col_q + 1'b1;
                end
            end else if (wr_en && wr_ready) begin
                wr_en <= 1'b0;
            end

            occ_q <= occ_q + OCC_W'(push) - OCC_W'(pop);

            if (last_hs) begin
                state_q <= DONE;
            end
        end
    end

endmodule
